// File: rtl/pifo_reg_hs.sv
// Register-array push-in/first-out queue with valid/ready handshakes.
// A balanced comparator tree picks the min/max-rank head; ties go to the oldest slot.
module pifo_reg_hs #(
    parameter int unsigned L2_MAX_SIZE = 3,
    parameter int unsigned RANK_WIDTH  = 16,
    parameter int unsigned META_WIDTH  = 32,
    parameter int unsigned MAX_FIRST   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [RANK_WIDTH-1:0]  in_rank,
    input  logic [META_WIDTH-1:0]  in_meta,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [RANK_WIDTH-1:0]  out_rank,
    output logic [META_WIDTH-1:0]  out_meta,
    output logic [L2_MAX_SIZE:0]   count,
    output logic                   full,
    output logic                   empty,
    output logic [15:0]            drop_cnt
);

    localparam int unsigned MAX_SIZE = 1 << L2_MAX_SIZE;
    localparam int unsigned CW       = L2_MAX_SIZE + 1;
    localparam int unsigned IW       = L2_MAX_SIZE;

    typedef enum logic [1:0] {S_EMPTY, S_CALC, S_HEAD} state_t;

    state_t                 state_q;
    logic [RANK_WIDTH-1:0]  rank_q [MAX_SIZE];
    logic [META_WIDTH-1:0]  meta_q [MAX_SIZE];
    logic [MAX_SIZE-1:0]    vld_q;
    logic [CW-1:0]          count_q;
    logic [IW-1:0]          head_idx_q;
    logic                   out_valid_q;
    logic [RANK_WIDTH-1:0]  out_rank_q;
    logic [META_WIDTH-1:0]  out_meta_q;
    logic [15:0]            drop_cnt_q;

    logic [RANK_WIDTH-1:0]  rank_d [MAX_SIZE];
    logic [META_WIDTH-1:0]  meta_d [MAX_SIZE];
    logic [MAX_SIZE-1:0]    vld_d;
    logic [CW-1:0]          wr_idx;
    logic                   push;
    logic                   pop;

    assign full      = (count_q == CW'(MAX_SIZE));
    assign empty     = (count_q == CW'(0));
    assign pop       = out_valid_q & out_ready;
    assign in_ready  = ~full | pop;
    assign push      = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign out_rank  = out_rank_q;
    assign out_meta  = out_meta_q;
    assign count     = count_q;
    assign drop_cnt  = drop_cnt_q;

    // Next array: remove the head and close the gap, then append the push.
    always_comb begin
        for (int i = 0; i < MAX_SIZE; i++) begin
            rank_d[i] = rank_q[i];
            meta_d[i] = meta_q[i];
        end
        vld_d  = vld_q;
        wr_idx = pop ? (count_q - CW'(1)) : count_q;
        if (pop) begin
            for (int i = 0; i < MAX_SIZE - 1; i++) begin
                if (IW'(i) >= head_idx_q) begin
                    rank_d[i] = rank_q[i+1];
                    meta_d[i] = meta_q[i+1];
                    vld_d[i]  = vld_q[i+1];
                end
            end
            vld_d[MAX_SIZE-1] = 1'b0;
        end
        if (push) begin
            for (int i = 0; i < MAX_SIZE; i++) begin
                if (CW'(i) == wr_idx) begin
                    rank_d[i] = in_rank;
                    meta_d[i] = in_meta;
                    vld_d[i]  = 1'b1;
                end
            end
        end
    end

    logic [IW-1:0]          node_idx  [L2_MAX_SIZE+1][MAX_SIZE];
    logic                   node_vld  [L2_MAX_SIZE+1][MAX_SIZE];
    logic [RANK_WIDTH-1:0]  node_rank [L2_MAX_SIZE+1][MAX_SIZE];
    logic [IW-1:0]          win_idx;
    logic                   win_vld;
    logic [RANK_WIDTH-1:0]  win_rank;

    // Pairwise reduction; the right (younger) child only wins when strictly better.
    always_comb begin
        for (int lv = 0; lv <= L2_MAX_SIZE; lv++) begin
            for (int n = 0; n < MAX_SIZE; n++) begin
                node_idx[lv][n]  = '0;
                node_vld[lv][n]  = 1'b0;
                node_rank[lv][n] = '0;
            end
        end
        for (int n = 0; n < MAX_SIZE; n++) begin
            node_idx[0][n]  = IW'(n);
            node_vld[0][n]  = vld_q[n];
            node_rank[0][n] = rank_q[n];
        end
        for (int lv = 1; lv <= L2_MAX_SIZE; lv++) begin
            for (int n = 0; n < (MAX_SIZE >> lv); n++) begin
                logic b_better;
                logic take_b;
                b_better = (MAX_FIRST != 0) ? (node_rank[lv-1][2*n+1] > node_rank[lv-1][2*n])
                                            : (node_rank[lv-1][2*n+1] < node_rank[lv-1][2*n]);
                take_b   = node_vld[lv-1][2*n+1] & (~node_vld[lv-1][2*n] | b_better);
                node_idx[lv][n]  = take_b ? node_idx[lv-1][2*n+1]  : node_idx[lv-1][2*n];
                node_vld[lv][n]  = take_b ? node_vld[lv-1][2*n+1]  : node_vld[lv-1][2*n];
                node_rank[lv][n] = take_b ? node_rank[lv-1][2*n+1] : node_rank[lv-1][2*n];
            end
        end
        win_idx  = node_idx[L2_MAX_SIZE][0];
        win_vld  = node_vld[L2_MAX_SIZE][0];
        win_rank = node_rank[L2_MAX_SIZE][0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_SIZE; i++) begin
                rank_q[i] <= '0;
                meta_q[i] <= '0;
            end
            vld_q      <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            for (int i = 0; i < MAX_SIZE; i++) begin
                rank_q[i] <= rank_d[i];
                meta_q[i] <= meta_d[i];
            end
            vld_q   <= vld_d;
            count_q <= count_q + CW'(push) - CW'(pop);
            if (in_valid && !in_ready && drop_cnt_q != 16'hFFFF)
                drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    // Head-selection FSM; every push or pop forces one CALC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            out_valid_q <= 1'b0;
            out_rank_q  <= '0;
            out_meta_q  <= '0;
            head_idx_q  <= '0;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (push) begin
                        state_q     <= S_CALC;
                        out_valid_q <= 1'b0;
                    end
                end
                S_CALC: begin
                    if (win_vld) begin
                        out_rank_q <= win_rank;
                        out_meta_q <= meta_q[win_idx];
                        head_idx_q <= win_idx;
                    end
                    if (push) begin
                        state_q     <= S_CALC;
                        out_valid_q <= 1'b0;
                    end else if (count_q != CW'(0)) begin
                        state_q     <= S_HEAD;
                        out_valid_q <= 1'b1;
                    end else begin
                        state_q     <= S_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                S_HEAD: begin
                    if (push || pop) begin
                        state_q     <= S_CALC;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_EMPTY;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pifo_reg_hs.sv
// Directed bench for pifo_reg_hs: a min-first and a max-first instance sharing clock and reset.
module tb_pifo_reg_hs;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv0 = 1'b0, ir0, ov0, ordy0 = 1'b0, full0, empty0;
    logic [15:0] rk0 = '0, ork0, drop0;
    logic [31:0] mt0 = '0, omt0;
    logic [3:0]  cnt0;

    logic        iv1 = 1'b0, ir1, ov1, ordy1 = 1'b0, full1, empty1;
    logic [15:0] rk1 = '0, ork1, drop1;
    logic [31:0] mt1 = '0, omt1;
    logic [3:0]  cnt1;

    int checks   = 0;
    int failures = 0;

    pifo_reg_hs #(.L2_MAX_SIZE(3), .RANK_WIDTH(16), .META_WIDTH(32), .MAX_FIRST(0)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(iv0), .in_ready(ir0), .in_rank(rk0), .in_meta(mt0),
        .out_valid(ov0), .out_ready(ordy0), .out_rank(ork0), .out_meta(omt0),
        .count(cnt0), .full(full0), .empty(empty0), .drop_cnt(drop0)
    );

    pifo_reg_hs #(.L2_MAX_SIZE(3), .RANK_WIDTH(16), .META_WIDTH(32), .MAX_FIRST(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(iv1), .in_ready(ir1), .in_rank(rk1), .in_meta(mt1),
        .out_valid(ov1), .out_ready(ordy1), .out_rank(ork1), .out_meta(omt1),
        .count(cnt1), .full(full1), .empty(empty1), .drop_cnt(drop1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [15:0] r, input logic [31:0] m);
        iv0 = 1'b1; rk0 = r; mt0 = m;
        step();
        iv0 = 1'b0;
    endtask

    task automatic push1(input logic [15:0] r, input logic [31:0] m);
        iv1 = 1'b1; rk1 = r; mt1 = m;
        step();
        iv1 = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (ov0 !== 1'b0)    begin failures++; $display("FAIL reset_out_valid got=%b exp=0", ov0); end
        checks++; if (cnt0 !== 4'd0)   begin failures++; $display("FAIL reset_count got=%0d exp=0", cnt0); end
        checks++; if (empty0 !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty0); end
        checks++; if (full0 !== 1'b0)  begin failures++; $display("FAIL reset_full got=%b exp=0", full0); end
        checks++; if (ir0 !== 1'b1)    begin failures++; $display("FAIL reset_in_ready got=%b exp=1", ir0); end
        checks++; if (drop0 !== 16'd0) begin failures++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop0); end
        checks++; if (ov1 !== 1'b0)    begin failures++; $display("FAIL reset_out_valid_max got=%b exp=0", ov1); end
    endtask

    task automatic test_min_first_tie();
        logic [15:0] er [4];
        logic [31:0] em [4];
        er = '{16'd2, 16'd2, 16'd5, 16'd9};
        em = '{32'hB, 32'hD, 32'hA, 32'hC};
        push0(16'd5, 32'hA);
        push0(16'd2, 32'hB);
        push0(16'd9, 32'hC);
        push0(16'd2, 32'hD);
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 20 && !ov0; n++) step();
            checks++; if (ov0 !== 1'b1) begin failures++; $display("FAIL min_head_timeout pop=%0d got=%b exp=1", k, ov0); end
            checks++; if (ork0 !== er[k]) begin failures++; $display("FAIL min_rank pop=%0d got=%0d exp=%0d", k, ork0, er[k]); end
            checks++; if (omt0 !== em[k]) begin failures++; $display("FAIL min_meta pop=%0d got=%h exp=%h", k, omt0, em[k]); end
            ordy0 = 1'b1;
            step();
            ordy0 = 1'b0;
        end
        step();
        step();
        checks++; if (empty0 !== 1'b1) begin failures++; $display("FAIL min_drained_empty got=%b exp=1", empty0); end
        checks++; if (ov0 !== 1'b0)    begin failures++; $display("FAIL min_drained_out_valid got=%b exp=0", ov0); end
    endtask

    task automatic test_full_drop();
        for (int i = 0; i < 8; i++) push0(16'(10 + i), 32'(32'h100 + i));
        for (int n = 0; n < 20 && !ov0; n++) step();
        checks++; if (full0 !== 1'b1) begin failures++; $display("FAIL full_flag got=%b exp=1", full0); end
        checks++; if (cnt0 !== 4'd8)  begin failures++; $display("FAIL full_count got=%0d exp=8", cnt0); end
        iv0 = 1'b1; rk0 = 16'd20; mt0 = 32'hDEAD;
        #1;
        checks++; if (ir0 !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", ir0); end
        step();
        iv0 = 1'b0;
        checks++; if (drop0 !== 16'd1) begin failures++; $display("FAIL drop_cnt got=%0d exp=1", drop0); end
        checks++; if (cnt0 !== 4'd8)   begin failures++; $display("FAIL drop_count got=%0d exp=8", cnt0); end
        checks++; if (ov0 !== 1'b1)    begin failures++; $display("FAIL drop_hold_valid got=%b exp=1", ov0); end
        checks++; if (ork0 !== 16'd10) begin failures++; $display("FAIL drop_head_rank got=%0d exp=10", ork0); end
    endtask

    task automatic test_full_push_pop();
        iv0 = 1'b1; rk0 = 16'd1; mt0 = 32'h111; ordy0 = 1'b1;
        #1;
        checks++; if (ir0 !== 1'b1) begin failures++; $display("FAIL pp_in_ready got=%b exp=1", ir0); end
        step();
        iv0 = 1'b0; ordy0 = 1'b0;
        checks++; if (cnt0 !== 4'd8) begin failures++; $display("FAIL pp_count got=%0d exp=8", cnt0); end
        for (int n = 0; n < 20 && !ov0; n++) step();
        checks++; if (ov0 !== 1'b1)     begin failures++; $display("FAIL pp_head_timeout got=%b exp=1", ov0); end
        checks++; if (ork0 !== 16'd1)   begin failures++; $display("FAIL pp_head_rank got=%0d exp=1", ork0); end
        checks++; if (omt0 !== 32'h111) begin failures++; $display("FAIL pp_head_meta got=%h exp=111", omt0); end
    endtask

    task automatic test_max_first();
        logic [15:0] er [4];
        logic [31:0] em [4];
        er = '{16'd7, 16'd7, 16'd3, 16'd1};
        em = '{32'h2, 32'h3, 32'h1, 32'h4};
        push1(16'd3, 32'h1);
        push1(16'd7, 32'h2);
        push1(16'd7, 32'h3);
        push1(16'd1, 32'h4);
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 20 && !ov1; n++) step();
            checks++; if (ov1 !== 1'b1) begin failures++; $display("FAIL max_head_timeout pop=%0d got=%b exp=1", k, ov1); end
            checks++; if (ork1 !== er[k]) begin failures++; $display("FAIL max_rank pop=%0d got=%0d exp=%0d", k, ork1, er[k]); end
            checks++; if (omt1 !== em[k]) begin failures++; $display("FAIL max_meta pop=%0d got=%h exp=%h", k, omt1, em[k]); end
            ordy1 = 1'b1;
            step();
            ordy1 = 1'b0;
        end
        step();
        step();
        checks++; if (empty1 !== 1'b1) begin failures++; $display("FAIL max_empty got=%b exp=1", empty1); end
        checks++; if (ov1 !== 1'b0)    begin failures++; $display("FAIL max_out_valid got=%b exp=0", ov1); end
    endtask

    task automatic test_reset_mid_op();
        apply_reset();
        for (int i = 0; i < 4; i++) push0(16'(40 + i), 32'(32'h400 + i));
        for (int n = 0; n < 20 && !ov0; n++) step();
        checks++; if (ov0 !== 1'b1)  begin failures++; $display("FAIL mid_pre_valid got=%b exp=1", ov0); end
        checks++; if (cnt0 !== 4'd4) begin failures++; $display("FAIL mid_pre_count got=%0d exp=4", cnt0); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (ov0 !== 1'b0)    begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", ov0); end
        checks++; if (cnt0 !== 4'd0)   begin failures++; $display("FAIL mid_rst_count got=%0d exp=0", cnt0); end
        checks++; if (ork0 !== 16'd0)  begin failures++; $display("FAIL mid_rst_rank got=%0d exp=0", ork0); end
        checks++; if (empty0 !== 1'b1) begin failures++; $display("FAIL mid_rst_empty got=%b exp=1", empty0); end
        step();
        rst = 1'b0;
        step();
        iv0 = 1'b1; rk0 = 16'd7; mt0 = 32'h77;
        step();
        iv0 = 1'b0;
        checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL lat_edge1_valid got=%b exp=0", ov0); end
        step();
        checks++; if (ov0 !== 1'b1)   begin failures++; $display("FAIL lat_edge2_valid got=%b exp=1", ov0); end
        checks++; if (ork0 !== 16'd7) begin failures++; $display("FAIL lat_rank got=%0d exp=7", ork0); end
    endtask

    initial begin
        test_reset();
        test_min_first_tie();
        test_full_drop();
        test_full_push_pop();
        test_max_first();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
